// File: rtl/ro_seq_pkg.sv
// Shared definitions for the 5-bit state-sequence generator and its checker.
// Both ends use seq_next so the prediction can never drift from the source.
package ro_seq_pkg;

    localparam int SEQ_W = 5;

    // Checker FSM state encoding
    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // Maximal-length next-state function, period 31; 00000 is the lockup state
    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count enabled events, holding once the maximum value is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ro_seq_checker.sv
// Receiving end of the state-sequence generator: predicts each sample with
// seq_next, locks after LOCK_CNT correct predictions, flags mismatches while
// locked, and falls back to hunting after LOSS_CNT consecutive misses.
// Only W = 5 is meaningful because seq_next is defined for 5 bits.
module ro_seq_checker
    import ro_seq_pkg::*;
#(
    parameter int W        = 5,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [W-1:0]     RxState,
    output logic             Locked,
    output logic             Err,
    output logic             ZeroFlag,
    output logic [ERR_W-1:0] ErrCnt,
    output logic [W-1:0]     Expected
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    logic [1:0]   state_q,    state_d;
    logic [W-1:0] expected_q, expected_d;
    logic [3:0]   matchCnt_q, matchCnt_d;
    logic [3:0]   missCnt_q,  missCnt_d;
    logic         locked_q;
    logic         err_q;
    logic         zeroFlag_q, zeroFlag_d;
    logic         errHit;
    logic         sampleZero;
    logic         sampleHit;
    logic [3:0]   matchNext;
    logic [3:0]   missNext;

    assign sampleZero = (RxState == '0);
    assign sampleHit  = (RxState == expected_q);
    assign matchNext  = matchCnt_q + 4'd1;
    assign missNext   = missCnt_q + 4'd1;

    // Next-state logic: one transition per valid sample, everything holds otherwise
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        matchCnt_d = matchCnt_q;
        missCnt_d  = missCnt_q;
        errHit     = 1'b0;
        zeroFlag_d = 1'b0;
        if (Valid) begin
            zeroFlag_d = sampleZero;
            case (state_q)
                HUNT: begin
                    if (!sampleZero) begin
                        expected_d = seq_next(RxState);
                        matchCnt_d = '0;
                        state_d    = ACQ;
                    end
                end
                ACQ: begin
                    if (sampleHit) begin
                        matchCnt_d = matchNext;
                        expected_d = seq_next(RxState);
                        if (matchNext == LOCK_C) begin
                            state_d   = LOCKED;
                            missCnt_d = '0;
                        end
                    end else if (!sampleZero) begin
                        expected_d = seq_next(RxState);
                        matchCnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: a bad sample must never corrupt the prediction
                    expected_d = seq_next(expected_q);
                    if (sampleHit) begin
                        missCnt_d = '0;
                    end else begin
                        errHit    = 1'b1;
                        missCnt_d = missNext;
                        if (missNext == LOSS_C) begin
                            state_d   = HUNT;
                            missCnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State, prediction and registered output flags
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= HUNT;
            expected_q <= '0;
            matchCnt_q <= '0;
            missCnt_q  <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            zeroFlag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            matchCnt_q <= matchCnt_d;
            missCnt_q  <= missCnt_d;
            locked_q   <= (state_d == LOCKED);
            err_q      <= errHit;
            zeroFlag_q <= zeroFlag_d;
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) uErrCnt (
        .clk     (CLK),
        .rst_n   (Reset),
        .en_i    (errHit),
        .count_o (ErrCnt)
    );

    assign Locked   = locked_q;
    assign Err      = err_q;
    assign ZeroFlag = zeroFlag_q;
    assign Expected = expected_q;

endmodule

// File: tb/tb_ro_seq_checker.sv
// Bench for ro_seq_checker: a default instance and a saturation instance
// (ERR_W=2, LOSS_CNT=15) share the stimulus; a behavioural model of each is
// compared every cycle, with literal expectations at key points.
module tb_ro_seq_checker;

    logic       CLK;
    logic       Reset;
    logic       Valid;
    logic [4:0] RxState;

    logic       lockedA, errA, zeroA;
    logic [7:0] errCntA;
    logic [4:0] expA;
    logic       lockedB, errB, zeroB;
    logic [1:0] errCntB;
    logic [4:0] expB;

    int checks = 0;
    int errors = 0;
    bit compareOn = 0;

    typedef struct {
        int phase;   // 0 hunting, 1 acquiring, 2 locked
        int pred;
        int run;
        int misses;
        bit lock;
        bit err;
        bit zf;
        int cnt;
    } model_t;

    model_t mA, mB;

    ro_seq_checker dutA (
        .CLK(CLK), .Reset(Reset), .Valid(Valid), .RxState(RxState),
        .Locked(lockedA), .Err(errA), .ZeroFlag(zeroA),
        .ErrCnt(errCntA), .Expected(expA)
    );

    ro_seq_checker #(.W(5), .LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) dutB (
        .CLK(CLK), .Reset(Reset), .Valid(Valid), .RxState(RxState),
        .Locked(lockedB), .Err(errB), .ZeroFlag(zeroB),
        .ErrCnt(errCntB), .Expected(expB)
    );

    // Free-running 10-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Sequence step written arithmetically: shift left, feed back bit4 xor bit2
    function automatic int nxt(input int s);
        return ((s * 2) % 32) + (((s / 16) + (s / 4)) % 2);
    endfunction

    function automatic model_t resetModel();
        model_t r;
        r.phase = 0; r.pred = 0; r.run = 0; r.misses = 0;
        r.lock = 0; r.err = 0; r.zf = 0; r.cnt = 0;
        return r;
    endfunction

    function automatic model_t step(input model_t m, input bit v, input int s,
                                    input int lockN, input int lossN, input int cntMax);
        model_t r = m;
        r.err = 0;
        r.zf  = 0;
        if (!v) return r;
        r.zf = (s == 0);
        if (m.phase == 0) begin
            if (s != 0) begin
                r.phase = 1; r.pred = nxt(s); r.run = 0;
            end
        end else if (m.phase == 1) begin
            if (s == m.pred) begin
                r.run  = m.run + 1;
                r.pred = nxt(s);
                if (r.run == lockN) begin
                    r.phase = 2; r.misses = 0;
                end
            end else if (s != 0) begin
                r.pred = nxt(s); r.run = 0;
            end else begin
                r.phase = 0;
            end
        end else begin
            r.pred = nxt(m.pred);
            if (s == m.pred) begin
                r.misses = 0;
            end else begin
                r.err    = 1;
                r.cnt    = (m.cnt < cntMax) ? m.cnt + 1 : cntMax;
                r.misses = m.misses + 1;
                if (r.misses == lossN) begin
                    r.phase = 0; r.misses = 0;
                end
            end
        end
        r.lock = (r.phase == 2);
        return r;
    endfunction

    // Advance both models on the same edges the DUTs see, including async reset
    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mA = resetModel();
            mB = resetModel();
        end else begin
            mA = step(mA, Valid, int'(RxState), 4, 3, 255);
            mB = step(mB, Valid, int'(RxState), 4, 15, 3);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against its model on each falling edge
    always @(negedge CLK) begin
        if (compareOn && Reset === 1'b1) begin
            checkOutput("A.Locked",   int'(lockedA), int'(mA.lock));
            checkOutput("A.Err",      int'(errA),    int'(mA.err));
            checkOutput("A.ZeroFlag", int'(zeroA),   int'(mA.zf));
            checkOutput("A.ErrCnt",   int'(errCntA), mA.cnt);
            checkOutput("A.Expected", int'(expA),    mA.pred);
            checkOutput("B.Locked",   int'(lockedB), int'(mB.lock));
            checkOutput("B.Err",      int'(errB),    int'(mB.err));
            checkOutput("B.ZeroFlag", int'(zeroB),   int'(mB.zf));
            checkOutput("B.ErrCnt",   int'(errCntB), mB.cnt);
            checkOutput("B.Expected", int'(expB),    mB.pred);
        end
    end

    // Drive one sample at a falling edge; returns at the falling edge after it was taken
    task automatic applyStimulus(input bit v, input logic [4:0] s);
        Valid   = v;
        RxState = s;
        @(negedge CLK);
    endtask

    task automatic doReset();
        Valid   = 1'b0;
        RxState = 5'd0;
        Reset   = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic lockSeq(input bit bubbles);
        int seq[5] = '{2, 4, 9, 18, 5};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'(seq[i]));
            if (bubbles) applyStimulus(1'b0, 5'd31);
        end
    endtask

    // Directed scenarios with hand-computed expectations
    initial begin
        Reset   = 1'b0;
        Valid   = 1'b0;
        RxState = 5'd0;
        @(negedge CLK);
        checkOutput("reset.Locked",   int'(lockedA), 0);
        checkOutput("reset.Expected", int'(expA),    0);
        checkOutput("reset.ErrCnt",   int'(errCntA), 0);
        compareOn = 1;

        // Lock acquisition
        doReset();
        applyStimulus(1'b1, 5'd2);
        checkOutput("acq.Expected1", int'(expA), 4);
        applyStimulus(1'b1, 5'd4);
        applyStimulus(1'b1, 5'd9);
        applyStimulus(1'b1, 5'd18);
        checkOutput("acq.notYetLocked", int'(lockedA), 0);
        applyStimulus(1'b1, 5'd5);
        checkOutput("acq.Locked",   int'(lockedA), 1);
        checkOutput("acq.Expected", int'(expA),    11);
        checkOutput("acq.ErrCnt",   int'(errCntA), 0);

        // Single error while locked
        applyStimulus(1'b1, 5'd11);
        checkOutput("single.noErr", int'(errA), 0);
        applyStimulus(1'b1, 5'd7);
        checkOutput("single.Err",      int'(errA),    1);
        checkOutput("single.ErrCnt",   int'(errCntA), 1);
        checkOutput("single.Expected", int'(expA),    12);
        applyStimulus(1'b1, 5'd12);
        checkOutput("single.errClear", int'(errA),    0);
        checkOutput("single.Locked",   int'(lockedA), 1);
        checkOutput("single.flywheel", int'(expA),    25);

        // Lock loss after three consecutive misses
        doReset();
        lockSeq(1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd1);
            checkOutput("loss.ErrPulse", int'(errA), 1);
        end
        checkOutput("loss.Locked", int'(lockedA), 0);
        checkOutput("loss.ErrCnt", int'(errCntA), 3);
        applyStimulus(1'b1, 5'd6);
        checkOutput("loss.reseed", int'(expA),    13);
        checkOutput("loss.noErr",  int'(errA),    0);

        // Zero samples in HUNT and while locked
        doReset();
        applyStimulus(1'b1, 5'd0);
        checkOutput("zeroHunt.ZeroFlag", int'(zeroA), 1);
        checkOutput("zeroHunt.Expected", int'(expA),  0);
        applyStimulus(1'b1, 5'd6);
        checkOutput("zeroHunt.seed", int'(expA),  13);
        checkOutput("zeroHunt.zfOff", int'(zeroA), 0);
        lockSeq(1'b0);
        checkOutput("zeroLock.Locked", int'(lockedA), 1);
        applyStimulus(1'b1, 5'd0);
        checkOutput("zeroLock.ZeroFlag", int'(zeroA),   1);
        checkOutput("zeroLock.Err",      int'(errA),    1);
        checkOutput("zeroLock.ErrCnt",   int'(errCntA), 1);

        // Lock acquisition with Valid bubbles
        doReset();
        applyStimulus(1'b1, 5'd2);
        applyStimulus(1'b0, 5'd31);
        checkOutput("gap.holdExpected", int'(expA), 4);
        lockSeq(1'b1);
        checkOutput("gap.Locked", int'(lockedA), 1);
        checkOutput("gap.ErrCnt", int'(errCntA), 0);

        // Asynchronous reset between clock edges while locked
        doReset();
        lockSeq(1'b0);
        applyStimulus(1'b1, 5'd1);
        Valid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        checkOutput("async.Locked",   int'(lockedA), 0);
        checkOutput("async.ErrCnt",   int'(errCntA), 0);
        checkOutput("async.Expected", int'(expA),    0);
        @(negedge CLK);
        Reset = 1'b1;

        // Saturation on the narrow counter instance
        lockSeq(1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'd1);
        checkOutput("sat.B.ErrCnt", int'(errCntB), 3);
        checkOutput("sat.B.Locked", int'(lockedB), 1);
        checkOutput("sat.A.ErrCnt", int'(errCntA), 3);
        checkOutput("sat.A.Locked", int'(lockedA), 0);
        applyStimulus(1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_seq_checker.md
Name: ro_seq_checker

Overview:
- Receiving end of the 5-bit state-sequence generator: samples the generator's RO stream and predicts each next value with the same next-state function.
- Acquires lock after a run of correct predictions, then flags and counts mismatches.
- Drops lock after repeated consecutive misses.
- Sits downstream of the generator's RO output, in bench or loopback, as its self-check.

Parameters:
- W, 5, state/sample width; the next-state function is defined only for 5.
- LOCK_CNT, 4, consecutive correct predictions needed to enter LOCKED (range 1..15).
- LOSS_CNT, 3, consecutive mismatches in LOCKED that force return to HUNT (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Valid  in  1  RxState is a new sample this cycle.
- RxState  in  W  sampled generator output (RO).
- Locked  out  1  high while in LOCKED.
- Err  out  1  one-cycle pulse on a mismatch while LOCKED.
- ZeroFlag  out  1  one-cycle pulse when an all-zero sample is received (illegal state).
- ErrCnt  out  ERR_W  saturating mismatch count.
- Expected  out  W  current prediction of the next sample.

Behaviour:
- Next-state function nxt(s) = {s[3:0], s[4]^s[2]}.
  - Maximal length, period 31.
  - 00000 is the lockup state and is never a valid seed.
- All outputs are registered.
- Reset low, at any time including mid-sequence, immediately clears everything: state=HUNT, Locked=0, Err=0, ZeroFlag=0, ErrCnt=0, Expected=0, match_cnt=0, miss_cnt=0.
- Valid=0: all state and counters hold; Err and ZeroFlag are 0.
- Any Valid sample equal to 00000 pulses ZeroFlag on the next cycle, in every state.
- HUNT, on Valid:
  - Nonzero sample: Expected<=nxt(sample), match_cnt<=0, go to ACQ.
  - Zero sample: stay in HUNT.
- ACQ, on Valid:
  - sample==Expected: match_cnt++, Expected<=nxt(sample).
    - If match_cnt+1==LOCK_CNT: go to LOCKED and set Locked=1 the cycle after that sample.
  - Mismatch with nonzero sample: re-seed, Expected<=nxt(sample), match_cnt<=0, stay in ACQ. No Err pulse.
  - Mismatch with zero sample: go to HUNT.
- LOCKED, on Valid:
  - Expected always advances by flywheel, Expected<=nxt(Expected); it is never re-seeded from a bad sample.
  - Match: miss_cnt<=0.
  - Mismatch:
    - Err pulses the next cycle.
    - ErrCnt increments and saturates at 2^ERR_W-1; it does not wrap.
    - miss_cnt++.
    - If miss_cnt+1==LOSS_CNT: go to HUNT, Locked=0, miss_cnt<=0.
  - A zero sample counts as a mismatch.
- Latency: Err, ZeroFlag and Locked change exactly 1 cycle after the sampling edge.
- ErrCnt persists across lock loss and is cleared only by reset.
- A single Valid sample drives at most one state transition.

Decomposition:
- Shared package ro_seq_pkg holds:
  - state encoding: HUNT=2'd0, ACQ=2'd1, LOCKED=2'd2;
  - constant SEQ_W=5;
  - function seq_next(s), which the generator also uses so both ends share one definition.
- One natural sub-module, sat_counter (ERR_W wide, with enable, saturating), used for ErrCnt.
- The FSM, match/miss counters and prediction register live in ro_seq_checker.

Test Plan:
- Lock acquisition:
  - Stimulus: release Reset, then Valid each cycle with 2,4,9,18,5.
  - Required: Expected=4 after the first sample; Locked=1 one cycle after sample 5; Err never pulses; ErrCnt=0.
- Single error while locked:
  - Stimulus: after lock, send 11 (expected), then 7 (expected 22), then 12 (expected nxt(22)=12).
  - Required: one Err pulse after 7; ErrCnt=1; Locked stays 1; Expected keeps flywheeling.
- Lock loss:
  - Stimulus: after lock, 3 consecutive wrong samples.
  - Required: 3 Err pulses; ErrCnt=3; Locked=0 after the third; FSM in HUNT.
  - Follow-up: a subsequent nonzero sample re-seeds into ACQ.
- Zero state:
  - Stimulus: Valid sample 00000 in HUNT.
  - Required: ZeroFlag pulse; FSM stays in HUNT.
  - Stimulus: 00000 while locked.
  - Required: ZeroFlag and Err both pulse; ErrCnt increments.
- Valid gaps:
  - Stimulus: the lock sequence 2,4,9,18,5 with Valid=0 bubbles between samples.
  - Required: identical result to the first scenario; outputs hold during bubbles.
- Async reset mid-lock and saturation:
  - Stimulus: drop Reset between clock edges while locked.
  - Required: Locked=0, ErrCnt=0, Expected=0 immediately, with no clock edge.
  - Stimulus: with ERR_W=2, force 5 errors with LOSS_CNT=15.
  - Required: ErrCnt=3.
